// File: rtl/mem_access_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory-access stage.
// The master modport drives EX/MEM; the slave side is the stage itself.
interface mem_access_if;
    logic [31:0] ExMemAluout;
    logic [31:0] ExMemReadData2;
    logic [4:0]  ExMemDestination_Rt_RdOutput;
    logic        ExMemWriteRegEnable;
    logic        ExMemWriteMemoryEnable;
    logic        ExMemReadMemoryEnable;
    logic        ExMemwritebackRegCtrl;

    logic [31:0] MemWbAluout;
    logic [31:0] MemWbReadData;
    logic [4:0]  MemWbDestination;
    logic        MemWbWriteRegEnable;
    logic        MemWbwritebackRegCtrl;
    logic [31:0] WriteBackValue;
    logic        MemStall;
    logic        MisalignFault;

    modport master (
        output ExMemAluout, ExMemReadData2,
        output ExMemDestination_Rt_RdOutput,
        output ExMemWriteRegEnable, ExMemWriteMemoryEnable,
        output ExMemReadMemoryEnable, ExMemwritebackRegCtrl,
        input  MemWbAluout, MemWbReadData, MemWbDestination,
        input  MemWbWriteRegEnable, MemWbwritebackRegCtrl,
        input  WriteBackValue, MemStall, MisalignFault
    );

    modport slave (
        input  ExMemAluout, ExMemReadData2,
        input  ExMemDestination_Rt_RdOutput,
        input  ExMemWriteRegEnable, ExMemWriteMemoryEnable,
        input  ExMemReadMemoryEnable, ExMemwritebackRegCtrl,
        output MemWbAluout, MemWbReadData, MemWbDestination,
        output MemWbWriteRegEnable, MemWbwritebackRegCtrl,
        output WriteBackValue, MemStall, MisalignFault
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: word-addressed data memory with fixed access
// latency, upstream stall, sticky misalignment flag and MEM/WB register.
module mem_access_stage #(
    parameter int ADDR_WIDTH  = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_access_if.slave  bus
);
    localparam int         DEPTH  = 2 ** ADDR_WIDTH;
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] BUSY   = 1'b1;
    localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);
    localparam bit         SINGLE = (MEM_LATENCY == 1);

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mem_q [DEPTH];

    logic [31:0] alu_q, alu_d;
    logic [31:0] rdata_q, rdata_d;
    logic [4:0]  dst_q, dst_d;
    logic        wen_q, wen_d;
    logic        wbc_q, wbc_d;
    logic        flt_q, flt_d;

    logic                  access;
    logic                  misalign;
    logic                  aligned;
    logic                  complete;
    logic                  stall;
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           mem_rd;

    assign access   = bus.ExMemReadMemoryEnable
                    | bus.ExMemWriteMemoryEnable;
    assign misalign = bus.ExMemAluout[1:0] != 2'b00;
    assign aligned  = access & ~misalign;
    assign idx      = bus.ExMemAluout[ADDR_WIDTH+1:2];
    assign mem_rd   = mem_q[idx];

    always_comb begin
        complete = 1'b0;
        stall    = 1'b0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (aligned) begin
                    if (SINGLE) begin
                        complete = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = BUSY;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 4'd1) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = 4'd0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase
    end

    // A stalled cycle inserts a bubble; the payload fields are held.
    always_comb begin
        alu_d   = alu_q;
        rdata_d = rdata_q;
        dst_d   = dst_q;
        wen_d   = 1'b0;
        wbc_d   = 1'b0;
        flt_d   = flt_q;
        if (!stall) begin
            alu_d   = bus.ExMemAluout;
            dst_d   = bus.ExMemDestination_Rt_RdOutput;
            wen_d   = bus.ExMemWriteRegEnable & ~(access & misalign);
            wbc_d   = bus.ExMemwritebackRegCtrl;
            rdata_d = (complete & bus.ExMemReadMemoryEnable)
                    ? mem_rd : 32'd0;
        end
        if (state_q == IDLE && access && misalign) begin
            flt_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            alu_q   <= 32'd0;
            rdata_q <= 32'd0;
            dst_q   <= 5'd0;
            wen_q   <= 1'b0;
            wbc_q   <= 1'b0;
            flt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alu_q   <= alu_d;
            rdata_q <= rdata_d;
            dst_q   <= dst_d;
            wen_q   <= wen_d;
            wbc_q   <= wbc_d;
            flt_q   <= flt_d;
        end
    end

    // Contents survive reset; an edge seen while in reset never writes.
    always_ff @(posedge clk) begin
        if (rst_n && complete && bus.ExMemWriteMemoryEnable) begin
            mem_q[idx] <= bus.ExMemReadData2;
        end
    end

    assign bus.MemWbAluout           = alu_q;
    assign bus.MemWbReadData         = rdata_q;
    assign bus.MemWbDestination      = dst_q;
    assign bus.MemWbWriteRegEnable   = wen_q;
    assign bus.MemWbwritebackRegCtrl = wbc_q;
    assign bus.WriteBackValue        = wbc_q ? rdata_q : alu_q;
    assign bus.MemStall              = stall & rst_n;
    assign bus.MisalignFault         = flt_q;
endmodule
